// File: rtl/uart_icb_seq_pkg.sv
// Shared UART register map and defaults used by the ICB sequencer and its bench.
package uart_icb_seq_pkg;

    localparam logic [31:0] UART_CSR_ADDR  = 32'h1000_0000;
    localparam logic [31:0] UART_CTRL_ADDR = 32'h1000_0004;
    localparam logic [31:0] UART_DATA_ADDR = 32'h1000_0008;

    // CSR bit that flags the loopback byte as available
    localparam int unsigned UART_RDY_BIT = 4;

endpackage

// File: rtl/uart_icb_seq_if.sv
// ICB command/response bus between the sequencer (master) and the UART (slave).
interface uart_icb_seq_if;

    logic        o_icb_cmd_valid;
    logic        o_icb_cmd_ready;
    logic [31:0] o_icb_cmd_addr;
    logic        o_icb_cmd_read;
    logic [31:0] o_icb_cmd_wdata;
    logic        o_icb_rsp_valid;
    logic        o_icb_rsp_ready;
    logic [31:0] o_icb_rsp_rdata;

    modport master (
        output o_icb_cmd_valid, o_icb_cmd_addr, o_icb_cmd_read, o_icb_cmd_wdata, o_icb_rsp_ready,
        input  o_icb_cmd_ready, o_icb_rsp_valid, o_icb_rsp_rdata
    );

    modport slave (
        input  o_icb_cmd_valid, o_icb_cmd_addr, o_icb_cmd_read, o_icb_cmd_wdata, o_icb_rsp_ready,
        output o_icb_cmd_ready, o_icb_rsp_valid, o_icb_rsp_rdata
    );

endinterface

// File: rtl/uart_icb_xfer.sv
// Single-outstanding ICB master: one start pulse runs one command/response exchange.
module uart_icb_xfer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] addr,
    input  logic        read,
    input  logic [31:0] wdata,
    output logic        done,
    output logic [31:0] rdata,
    uart_icb_seq_if.master icb
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            icb.o_icb_cmd_valid <= 1'b0;
            icb.o_icb_cmd_addr  <= 32'h0;
            icb.o_icb_cmd_read  <= 1'b0;
            icb.o_icb_cmd_wdata <= 32'h0;
            icb.o_icb_rsp_ready <= 1'b0;
        end else if (start && !icb.o_icb_cmd_valid && !icb.o_icb_rsp_ready) begin
            icb.o_icb_cmd_valid <= 1'b1;
            icb.o_icb_cmd_addr  <= addr;
            icb.o_icb_cmd_read  <= read;
            icb.o_icb_cmd_wdata <= wdata;
        end else if (icb.o_icb_cmd_valid && icb.o_icb_cmd_ready) begin
            icb.o_icb_cmd_valid <= 1'b0;
            icb.o_icb_rsp_ready <= 1'b1;
        end else if (icb.o_icb_rsp_ready && icb.o_icb_rsp_valid) begin
            icb.o_icb_rsp_ready <= 1'b0;
        end
    end

    // Responses outside the response phase never reach done
    assign done  = icb.o_icb_rsp_ready && icb.o_icb_rsp_valid;
    assign rdata = icb.o_icb_rsp_rdata;

endmodule

// File: rtl/uart_icb_seq.sv
// UART bring-up and byte loopback sequencer: init writes, then per byte write DATA,
// poll CSR for ready, read DATA back, poll CSR for clear.
module uart_icb_seq
    import uart_icb_seq_pkg::*;
#(
    parameter logic [31:0] CSR_INIT  = 32'h0004_0201,
    parameter logic [31:0] CTRL_INIT = 32'h0000_0111,
    parameter logic [15:0] POLL_MAX  = 16'd1000,
    parameter int unsigned RDY_BIT   = UART_RDY_BIT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_data,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    uart_icb_seq_if.master icb,
    output logic       busy,
    output logic       timeout_err
);

    localparam logic [2:0] S_INIT_CSR  = 3'd0;
    localparam logic [2:0] S_INIT_CTRL = 3'd1;
    localparam logic [2:0] S_READY     = 3'd2;
    localparam logic [2:0] S_WR_DATA   = 3'd3;
    localparam logic [2:0] S_POLL_SET  = 3'd4;
    localparam logic [2:0] S_RD_DATA   = 3'd5;
    localparam logic [2:0] S_POLL_CLR  = 3'd6;

    typedef enum logic [2:0] {
        StInitCsr  = S_INIT_CSR,
        StInitCtrl = S_INIT_CTRL,
        StReady    = S_READY,
        StWrData   = S_WR_DATA,
        StPollSet  = S_POLL_SET,
        StRdData   = S_RD_DATA,
        StPollClr  = S_POLL_CLR
    } state_e;

    state_e      state_q;
    logic        issued_q;
    logic        start_q;
    logic [31:0] req_addr_q;
    logic        req_read_q;
    logic [31:0] req_wdata_q;
    logic [7:0]  byte_q;
    logic [15:0] poll_cnt_q;
    logic [15:0] poll_inc;
    logic        xfer_done;
    logic [31:0] xfer_rdata;
    logic        rdy;

    assign poll_inc = (poll_cnt_q == 16'hFFFF) ? poll_cnt_q : poll_cnt_q + 16'd1;
    assign rdy      = xfer_rdata[RDY_BIT[4:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StInitCsr;
            issued_q    <= 1'b0;
            start_q     <= 1'b0;
            req_addr_q  <= 32'h0;
            req_read_q  <= 1'b0;
            req_wdata_q <= 32'h0;
            byte_q      <= 8'h0;
            poll_cnt_q  <= 16'h0;
            tx_ready    <= 1'b0;
            rx_valid    <= 1'b0;
            rx_data     <= 8'h0;
            busy        <= 1'b1;
            timeout_err <= 1'b0;
        end else begin
            start_q  <= 1'b0;
            rx_valid <= 1'b0;
            // Every non-READY state issues exactly one access, then waits for its done
            if (state_q != StReady && !issued_q) begin
                start_q  <= 1'b1;
                issued_q <= 1'b1;
                case (state_q)
                    StInitCsr: begin
                        req_addr_q  <= UART_CSR_ADDR;
                        req_read_q  <= 1'b0;
                        req_wdata_q <= CSR_INIT;
                    end
                    StInitCtrl: begin
                        req_addr_q  <= UART_CTRL_ADDR;
                        req_read_q  <= 1'b0;
                        req_wdata_q <= CTRL_INIT;
                    end
                    StWrData: begin
                        req_addr_q  <= UART_DATA_ADDR;
                        req_read_q  <= 1'b0;
                        req_wdata_q <= {24'h0, byte_q};
                    end
                    StRdData: begin
                        req_addr_q  <= UART_DATA_ADDR;
                        req_read_q  <= 1'b1;
                        req_wdata_q <= 32'h0;
                    end
                    default: begin
                        req_addr_q  <= UART_CSR_ADDR;
                        req_read_q  <= 1'b1;
                        req_wdata_q <= 32'h0;
                    end
                endcase
            end
            if (xfer_done) begin
                issued_q <= 1'b0;
                case (state_q)
                    StInitCsr: state_q <= StInitCtrl;
                    StInitCtrl: begin
                        state_q  <= StReady;
                        tx_ready <= 1'b1;
                        busy     <= 1'b0;
                    end
                    StWrData: begin
                        state_q    <= StPollSet;
                        poll_cnt_q <= 16'h0;
                    end
                    StPollSet: begin
                        if (rdy) begin
                            state_q <= StRdData;
                        end else if (poll_inc >= POLL_MAX) begin
                            state_q     <= StReady;
                            tx_ready    <= 1'b1;
                            busy        <= 1'b0;
                            timeout_err <= 1'b1;
                        end else begin
                            poll_cnt_q <= poll_inc;
                        end
                    end
                    StRdData: begin
                        rx_valid   <= 1'b1;
                        rx_data    <= xfer_rdata[7:0];
                        state_q    <= StPollClr;
                        poll_cnt_q <= 16'h0;
                    end
                    StPollClr: begin
                        if (!rdy || poll_inc >= POLL_MAX) begin
                            state_q  <= StReady;
                            tx_ready <= 1'b1;
                            busy     <= 1'b0;
                            if (rdy) timeout_err <= 1'b1;
                        end else begin
                            poll_cnt_q <= poll_inc;
                        end
                    end
                    default: ;
                endcase
            end
            if (state_q == StReady && tx_valid && tx_ready) begin
                byte_q   <= tx_data;
                state_q  <= StWrData;
                tx_ready <= 1'b0;
                busy     <= 1'b1;
            end
        end
    end

    uart_icb_xfer u_xfer (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start_q),
        .addr  (req_addr_q),
        .read  (req_read_q),
        .wdata (req_wdata_q),
        .done  (xfer_done),
        .rdata (xfer_rdata),
        .icb   (icb)
    );

endmodule

// File: doc/uart_icb_seq.md
UART_ICB_SEQ -- requirements
Module: uart_icb_seq

Interface
REQ-001 SHALL have parameter CSR_INIT, default 32'h0004_0201, the value written to the UART CSR register at initialisation.
REQ-002 SHALL have parameter CTRL_INIT, default 32'h0000_0111, the value written to the UART CTRL register at initialisation.
REQ-003 SHALL have parameter POLL_MAX, default 16'd1000, the maximum number of CSR polls per wait phase.
REQ-004 SHALL have parameter RDY_BIT, default 4, the CSR bit index that flags the loopback byte as available.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 tx_valid / tx_ready  in / out  1 / 1  upstream byte handshake.
REQ-008 tx_data  in  8  byte to transmit.
REQ-009 rx_valid  out  1  one-cycle pulse: rx_data is valid.
REQ-010 rx_data  out  8  received byte.
REQ-011 o_icb_cmd_valid / o_icb_cmd_ready  out / in  1 / 1  ICB command handshake toward the UART.
REQ-012 o_icb_cmd_addr  out  32  register address; values come from the shared uart define header (CSR, CTRL, DATA).
REQ-013 o_icb_cmd_read  out  1  1 = read, 0 = write.
REQ-014 o_icb_cmd_wdata  out  32  write data.
REQ-015 o_icb_rsp_valid / o_icb_rsp_ready  in / out  1 / 1  ICB response handshake.
REQ-016 o_icb_rsp_rdata  in  32  read data.
REQ-017 busy  out  1  high whenever the FSM is not in READY.
REQ-018 timeout_err  out  1  sticky flag, set on poll exhaustion.

Function
REQ-019 Every ICB access SHALL proceed as follows:
- o_icb_cmd_valid is held with stable addr, read and wdata until the cycle in which o_icb_cmd_ready is high.
- o_icb_rsp_ready is then driven high until o_icb_rsp_valid is seen.
- Only one transaction is outstanding at a time.
- The next command is issued no earlier than the cycle after the response.
REQ-020 FSM states SHALL be INIT_CSR, INIT_CTRL, READY, WR_DATA, POLL_SET, RD_DATA and POLL_CLR.
REQ-021 After reset the FSM SHALL enter INIT_CSR and write CSR_INIT to CSR, then enter INIT_CTRL and write CTRL_INIT to CTRL, then enter READY.
REQ-022 In READY, tx_ready SHALL be 1 and tx_ready SHALL be 0 in every other state; the tx_valid&&tx_ready cycle captures tx_data and moves the FSM to WR_DATA.
REQ-023 WR_DATA SHALL write {24'h0, captured byte} to the DATA register, then move to POLL_SET.
REQ-024 POLL_SET SHALL read CSR repeatedly:
- rdata[RDY_BIT]=1 moves the FSM to RD_DATA.
- Otherwise the poll counter increments.
REQ-025 RD_DATA SHALL read the DATA register and, in the cycle after the response, pulse rx_valid for exactly one cycle with rx_data=rdata[7:0], then move to POLL_CLR.
REQ-026 POLL_CLR SHALL read CSR until rdata[RDY_BIT]=0, then return to READY.
REQ-027 The poll counter SHALL be 16 bit, cleared on entry to each poll state, and saturating.
- When the counter reaches POLL_MAX without the exit condition, timeout_err is set and the FSM returns to READY.
- No rx_valid is produced for that byte.
REQ-028 timeout_err SHALL clear only on reset; operation continues after a timeout.
REQ-029 o_icb_cmd_ready or o_icb_rsp_valid asserted for zero cycles SHALL stall the FSM indefinitely; it does not time out, because only polls are counted.
REQ-030 A o_icb_rsp_valid that arrives when no response is expected SHALL be ignored.

Reset
REQ-031 On rst_n low, asynchronously:
- The state is INIT_CSR.
- o_icb_cmd_valid, o_icb_rsp_ready, tx_ready, rx_valid and timeout_err are 0.
- rx_data, o_icb_cmd_addr, o_icb_cmd_wdata and the counter are 0.
- o_icb_cmd_read is 0.
REQ-032 Reset asserted mid-transaction SHALL abandon the transaction and restart initialisation; a lost byte is not reported.

Structure
REQ-033 Register addresses and the RDY_BIT default SHALL live in the shared uart define header; FSM state encodings SHALL be localparams in this module.
REQ-034 A single sub-module, uart_icb_xfer, SHALL implement the one-transaction ICB master handshake (start, addr, read, wdata -> done, rdata); the top module holds only the FSM and counter.

Verification
REQ-035 The bench SHALL cover these directed scenarios:
- Reset release with a UART model whose ready is always 1: first command is a write of 32'h0004_0201 to CSR, second is a write of 32'h0000_0111 to CTRL, then tx_ready=1.
- tx_data=8'hA5 with loopback to the UART model: DATA written 32'h0000_00A5, then CSR polled, then DATA read, then rx_valid pulses once with rx_data=8'hA5, then busy falls.
- 256 bytes 8'h00..8'hFF back-to-back: received sequence equals sent sequence and timeout_err stays 0.
- CSR bit4 never set, POLL_MAX=5: exactly 5 CSR reads, then timeout_err=1, no rx_valid, and the FSM returns to READY.
- o_icb_cmd_ready held low for 20 cycles: cmd_valid and cmd_addr remain stable for all 20 cycles.
- rst_n pulsed low during POLL_SET: outputs take reset values immediately, then the initialisation writes repeat.
